// File: rtl/depth_div_requester.sv
// rtl/depth_div_requester.sv - issues depth = NUMERATOR / offset on a shared divider and queues results
// Optional DEPTH_ROUND_EN: round the quotient to nearest, ties away from zero.
module depth_div_requester #(
  parameter int                       WIDTH      = 36,
  parameter int                       TAGW       = 10,
  parameter logic signed [WIDTH-1:0]  NUMERATOR  = 36'sd1000,
  parameter int                       FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_offset,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    div_start,
  output logic                    div_sign,
  output logic [WIDTH-1:0]        div_dividend,
  output logic [WIDTH-1:0]        div_divisor,
  input  logic [WIDTH-1:0]        div_quotient,
  input  logic [WIDTH-1:0]        div_remainder,
  input  logic                    div_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_depth,
  output logic [TAGW-1:0]         out_tag,
  output logic                    out_divzero
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DROP = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic             drop_cnt;
  logic [WIDTH-1:0] off_q;
  logic [TAGW-1:0]  tag_q;
  logic [WIDTH-1:0] quo_q;
  logic             zero_q;
  logic [WIDTH-1:0] wr_depth;

  logic [WIDTH-1:0] mem_depth [FIFO_DEPTH];
  logic [TAGW-1:0]  mem_tag   [FIFO_DEPTH];
  logic             mem_dz    [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [AW:0]      count, count_next;
  logic             push, pop, accept;

  assign in_ready    = !reset && (state == S_IDLE) && div_ready && (count < (AW+1)'(FIFO_DEPTH));
  assign accept      = in_valid && in_ready;
  assign div_start   = (state == S_ISSUE);
  assign div_sign    = 1'b1;
  assign div_divisor = off_q;

`ifdef DEPTH_ROUND_EN
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   rem_abs, dvs_abs;
  logic             q_neg;

  always_comb begin
    rem_abs = rem_q[WIDTH-1] ? -{rem_q[WIDTH-1], rem_q} : {rem_q[WIDTH-1], rem_q};
    dvs_abs = off_q[WIDTH-1] ? -{off_q[WIDTH-1], off_q} : {off_q[WIDTH-1], off_q};
    q_neg   = NUMERATOR[WIDTH-1] ^ off_q[WIDTH-1];
    wr_depth = quo_q;
    if (zero_q)
      wr_depth = MAX_POS;
    else if ((rem_abs << 1) >= dvs_abs)
      wr_depth = q_neg ? quo_q - ONE : quo_q + ONE;
  end
`else
  logic unused_rem;
  assign unused_rem = ^{div_remainder, ONE};

  always_comb begin
    wr_depth = zero_q ? MAX_POS : quo_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      drop_cnt     <= 1'b0;
      off_q        <= '0;
      tag_q        <= '0;
      quo_q        <= '0;
      zero_q       <= 1'b0;
      div_dividend <= '0;
`ifdef DEPTH_ROUND_EN
      rem_q        <= '0;
`endif
    end else begin
      div_dividend <= NUMERATOR;
      case (state)
        S_IDLE: begin
          if (accept) begin
            off_q  <= in_offset;
            tag_q  <= in_tag;
            zero_q <= (in_offset == '0);
            state  <= (in_offset == '0) ? S_WRITE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          drop_cnt <= 1'b0;
          state    <= S_WAIT_DROP;
        end
        S_WAIT_DROP: begin
          // a divider that never drops ready is assumed to have already finished
          if (!div_ready || drop_cnt)
            state <= S_WAIT_DONE;
          else
            drop_cnt <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (div_ready) begin
            quo_q <= div_quotient;
`ifdef DEPTH_ROUND_EN
            rem_q <= div_remainder;
`endif
            state <= S_WRITE;
          end
        end
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign push       = (state == S_WRITE);
  assign pop        = out_valid && out_ready;
  assign rd_next    = rd_ptr + AW'(pop);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_depth[wr_ptr] <= wr_depth;
      mem_tag[wr_ptr]   <= tag_q;
      mem_dz[wr_ptr]    <= zero_q;
    end
  end

  // head registers track the post-update pointers; bypass when the pushed entry becomes the head
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid   <= 1'b0;
      out_depth   <= '0;
      out_tag     <= '0;
      out_divzero <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (push && (count == (AW+1)'(pop))) begin
        out_depth   <= wr_depth;
        out_tag     <= tag_q;
        out_divzero <= zero_q;
      end else if (count_next != '0) begin
        out_depth   <= mem_depth[rd_next];
        out_tag     <= mem_tag[rd_next];
        out_divzero <= mem_dz[rd_next];
      end
    end
  end

endmodule

// File: tb/tb_depth_div_requester.sv
// tb/tb_depth_div_requester.sv - scoreboard bench for depth_div_requester with a behavioural divider
module tb_depth_div_requester;

  localparam longint NUM = 1000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [35:0]        in_offset = '0;
  logic [9:0]         in_tag = '0;
  logic               div_start, div_sign;
  logic signed [35:0] div_dividend, div_divisor;
  logic signed [35:0] div_quotient = '0, div_remainder = '0;
  logic               div_ready;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [35:0] out_depth;
  logic [9:0]         out_tag;
  logic               out_divzero;

  int total = 0;
  int bad = 0;
  int lat = 36;
  int busy = 0;
  int starts = 0;

  typedef struct {
    longint depth;
    int     tag;
    bit     dz;
  } exp_t;
  exp_t sbq[$];

  depth_div_requester dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_offset(in_offset), .in_tag(in_tag),
    .div_start(div_start), .div_sign(div_sign), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_ready(div_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_depth(out_depth),
    .out_tag(out_tag), .out_divzero(out_divzero)
  );

  always #5 clk = ~clk;

  // divider: ready low for exactly lat cycles after a start; it ignores the requester's reset
  assign div_ready = (busy == 0);
  always @(posedge clk) begin
    if (div_start) begin
      div_quotient  <= 36'(longint'(div_dividend) / longint'(div_divisor));
      div_remainder <= 36'(longint'(div_dividend) % longint'(div_divisor));
      busy          <= lat;
      starts        <= starts + 1;
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint exp_depth(input longint off);
    longint a, b, m;
    bit neg;
    if (off == 0) return (longint'(1) << 35) - 1;
    a   = (NUM < 0) ? -NUM : NUM;
    b   = (off < 0) ? -off : off;
    neg = (NUM < 0) ^ (off < 0);
`ifdef DEPTH_ROUND_EN
    m = (2 * a + b) / (2 * b);
`else
    m = a / b;
`endif
    return neg ? -m : m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("depth", out_depth, e.depth);
        check("tag", out_tag, e.tag);
        check("divzero", out_divzero, e.dz);
      end
    end
  end

  task automatic send(input longint off, input int tag);
    int n = 0;
    bit ok = 0;
    exp_t e;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_offset = 36'(off);
    in_tag    = 10'(tag);
    while (!ok && n < 1000) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      else n++;
    end
    if (ok) begin
      e.depth = exp_depth(off);
      e.tag   = tag;
      e.dz    = (off == 0);
      sbq.push_back(e);
    end else begin
      check("accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic measure(input string tag, input int exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    check(tag, n, exp);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (!(sbq.size() == 0 && in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 2000, 1);
  endtask

  initial begin
    int s0, hits;
    #200000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int s0, hits;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_sign", div_sign, 1);
    check("rst_divisor", div_divisor, 0);
    check("rst_dividend", div_dividend, 0);
    check("rst_depth", out_depth, 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;

    s0 = starts;
    send(8, 5);
    measure("lat_div", 40);
    repeat (3) @(posedge clk);
    check("starts_div", starts - s0, 1);
    check("dividend", div_dividend, NUM);

    send(-8, 6);
    send(6, 7);
    send(-6, 8);
    send(-3, 12);
    send(7, 13);
    wait_drain();

    s0 = starts;
    send(0, 9);
    measure("lat_zero", 2);
    repeat (3) @(posedge clk);
    check("starts_zero", starts - s0, 0);
    wait_drain();

    lat = 0;
    send(4, 11);
    wait_drain();
    lat = 1;
    send(-5, 14);
    wait_drain();
    lat = 36;

    out_ready = 1'b0;
    send(1, 20);
    send(2, 21);
    send(4, 22);
    send(5, 23);
    repeat (45) @(posedge clk);
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_valid", out_valid, 1);
    check("full_head", out_depth, 1000);
    fork
      send(10, 24);
    join_none
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    out_ready = 1'b0;
    send(1, 30);
    send(2, 31);
    send(4, 32);
    repeat (45) @(posedge clk);
    send(0, 33);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pushpop_room", in_ready, 1);
    check("pushpop_head", out_depth, 500);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    send(12, 40);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("mid_out_valid", out_valid, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_div_start", div_start, 0);
    check("mid_divisor", div_divisor, 0);
    check("mid_dividend", div_dividend, 0);
    check("mid_depth", out_depth, 0);
    check("mid_tag", out_tag, 0);
    hits = 0;
    s0 = starts;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    check("mid_no_write", hits, 0);
    check("mid_no_start", starts - s0, 0);
    send(25, 41);
    measure("lat_after_reset", 40);
    wait_drain();

    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/depth_div_requester.md
Name: depth_div_requester

Overview:
- Initiator for the shared multi-cycle signed divider's start/ready handshake.
- Accepts a stream of laser-line column offsets plus a tag, and computes depth = NUMERATOR / offset on an external divider instance.
- Buffers results in a small output FIFO, so the downstream point-cloud writer can apply backpressure.
- Sits between the laser-line peak finder and the point-cloud writer.

Parameters:
- WIDTH, 36: bit width of offset, numerator, divider operands and depth.
- TAGW, 10: width of the column tag carried alongside each sample.
- NUMERATOR, 36'sd1000: signed constant dividend (baseline*focal product).
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  sample available
- in_ready  out  1  block accepts sample this cycle
- in_offset  in  WIDTH  signed column offset (divisor)
- in_tag  in  TAGW  column tag
- div_start  out  1  one-cycle start pulse to divider
- div_sign  out  1  signed-mode select; constant 1
- div_dividend  out  WIDTH  held at NUMERATOR
- div_divisor  out  WIDTH  latched offset, held stable from start until the result is captured
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder
- div_ready  in  1  divider idle/result valid
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops when out_valid and out_ready are both high
- out_depth  out  WIDTH  signed depth at FIFO head
- out_tag  out  TAGW  tag at FIFO head
- out_divzero  out  1  head entry came from a zero offset

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous, active-high.
- Reset values: all outputs 0 (div_sign is the exception, constant 1); FIFO empty; FSM in IDLE.
- Reset mid-operation: reset during a divide drops the in-flight sample. The divider's late result is ignored, because the FSM restarts in IDLE. Before the first issue after reset, the FSM waits for div_ready=1.

FSM states:
- IDLE
  - in_ready = 1 only when div_ready=1 and the FIFO count is below FIFO_DEPTH.
  - On accept: latch offset and tag.
  - If offset==0: go to WRITE with depth = 2^(WIDTH-1)-1 and divzero=1. Sign is ignored and the divider is not started.
  - Otherwise: go to ISSUE.
- ISSUE
  - div_start=1 for exactly one cycle; go to WAIT_DROP.
- WAIT_DROP
  - Wait for div_ready=0, to ignore the stale ready from the previous result.
  - Timeout: after 2 cycles with div_ready still 1, proceed to WAIT_DONE anyway. This covers dividers that finish very fast.
- WAIT_DONE
  - On div_ready=1: capture quotient and remainder; go to WRITE.
- WRITE
  - Push {depth, tag, divzero} into the FIFO; return to IDLE.

Timing and ordering:
- Exactly one divide is in flight at a time.
- FIFO room is checked at accept, so WRITE never overflows.
- Accept-to-out_valid latency with an empty FIFO: divider latency + 4 cycles. For a zero offset it is 2 cycles.

FIFO:
- Registered head (out_* are registers).
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle leave the count unchanged; this also holds when full, because a pop frees the slot.
- Pop when empty is ignored.
- Order of results equals order of acceptance.

Arithmetic:
- Divider truncates toward zero; the remainder takes the dividend's sign.
- Default depth is the quotient unmodified.

Optional Feature:
- Macro: DEPTH_ROUND_EN.
- When defined, WRITE rounds to nearest, with ties away from zero:
  - If 2*|remainder| >= |divisor|, the magnitude is incremented by 1 in the quotient's sign direction.
  - The quotient's sign is the sign of NUMERATOR xor the sign of the divisor.
  - Use WIDTH+1-bit intermediates; no overflow is possible, since |q| < 2^(WIDTH-1)-1 whenever |divisor| >= 2.
  - Adds no cycles.
- Divzero entries are never rounded.
- When undefined: depth = truncated quotient.

Test Plan:
- Reset, then offset=8, tag=5, behavioural divider with 36-cycle latency -> exactly one div_start pulse; out_depth=125, out_tag=5, out_divzero=0, out_valid 40 cycles after accept.
- offset=-8 -> out_depth=-125. offset=6 -> 166 without DEPTH_ROUND_EN, 167 with it. offset=-6 with DEPTH_ROUND_EN -> -167.
- offset=0, tag=9 -> no div_start; out_depth=0x7FFFFFFFF, out_divzero=1, out_valid 2 cycles after accept.
- Hold out_ready=0, feed offsets 1,2,4,5,10 -> four entries {1000,500,250,200}, then in_ready=0. Raise out_ready -> pops arrive in order, then 100 for the fifth sample.
- Assert reset in WAIT_DONE -> all outputs 0 next cycle. The divider's later div_ready is ignored, no FIFO write occurs, and the next sample computes correctly.
- out_ready=1 with a full FIFO while WRITE pushes -> count stays FIFO_DEPTH and no entry is lost or duplicated.
